// File: rtl/sram_req_port_if.sv
// Request, response and SRAM-pin bundle for sram_req_port.
// The slave modport is the port block itself; the master modport is the requester/macro side.
interface sram_req_port_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 10,
   parameter int WMASK_WIDTH = 4
);
   logic                   req_valid;
   logic                   req_ready;
   logic                   req_we;
   logic [WMASK_WIDTH-1:0] req_wmask;
   logic [ADDR_WIDTH-1:0]  req_addr;
   logic [DATA_WIDTH-1:0]  req_wdata;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [DATA_WIDTH-1:0]  rsp_rdata;
   logic                   sram_we;
   logic [WMASK_WIDTH-1:0] sram_wmask;
   logic [ADDR_WIDTH-1:0]  sram_addr;
   logic [DATA_WIDTH-1:0]  sram_din;
   logic [DATA_WIDTH-1:0]  sram_dout;
   logic                   busy;

   modport slave (
      input  req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready, sram_dout,
      output req_ready, rsp_valid, rsp_rdata, sram_we, sram_wmask, sram_addr, sram_din, busy
   );

   modport master (
      output req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready, sram_dout,
      input  req_ready, rsp_valid, rsp_rdata, sram_we, sram_wmask, sram_addr, sram_din, busy
   );
endinterface

// File: rtl/sram_req_port.sv
// Valid/ready front-end for a 1-cycle-latency single-port SRAM macro.
// Read data is captured into a 2-entry response FIFO so the consumer may stall.
module sram_req_port #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 10,
   parameter int WMASK_WIDTH = 4,
   parameter int RSP_DEPTH   = 2
) (
   input  logic              clk,
   input  logic              rstb,
   sram_req_port_if.slave    bus
);
   logic                  inflight;
   logic [1:0]            count;
   logic                  rd_ptr, wr_ptr;
   logic [DATA_WIDTH-1:0] rsp_buf [RSP_DEPTH];
   logic                  fire, push, pop, rsp_vld;

   assign rsp_vld = (count != 2'd0);
   assign pop     = rsp_vld & bus.rsp_ready;
   assign push    = inflight;

   // A read needs a slot to exist when its data lands next cycle: occupancy
   // (buffered + in flight + this read) net of this cycle's pop must fit.
   assign bus.req_ready = rstb & (bus.req_we |
                          ((int'(count) + int'(inflight)) < (RSP_DEPTH + int'(pop))));
   assign fire = bus.req_valid & bus.req_ready;

   assign bus.sram_we    = fire & bus.req_we;
   assign bus.sram_wmask = (fire & bus.req_we) ? bus.req_wmask : '0;
   assign bus.sram_addr  = bus.req_addr;
   assign bus.sram_din   = bus.req_wdata;

   assign bus.rsp_valid = rsp_vld;
   assign bus.rsp_rdata = rsp_buf[rd_ptr];
   assign bus.busy      = inflight | rsp_vld;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         inflight <= 1'b0;
         count    <= 2'd0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         for (int i = 0; i < RSP_DEPTH; i++) rsp_buf[i] <= '0;
      end else begin
         inflight <= fire & ~bus.req_we;
         if (push) begin
            rsp_buf[wr_ptr] <= bus.sram_dout;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rstb)
      !(push && count == 2'(RSP_DEPTH) && !pop));
endmodule

// File: tb/tb_sram_req_port.sv
// Bench for sram_req_port: behavioural SRAM, queue-based reference model, directed + random traffic.
module tb_sram_req_port;
   logic clk  = 1'b0;
   logic rstb = 1'b0;
   always #5 clk = ~clk;

   sram_req_port_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WMASK_WIDTH(4)) bus ();

   sram_req_port #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WMASK_WIDTH(4), .RSP_DEPTH(2)) dut (
      .clk  (clk),
      .rstb (rstb),
      .bus  (bus)
   );

   // SRAM macro model: 1-cycle read, byte-masked write
   logic [31:0] mem [1024];
   always @(posedge clk) begin
      if (bus.sram_we) begin
         for (int l = 0; l < 4; l++)
            if (bus.sram_wmask[l]) mem[bus.sram_addr][8*l +: 8] <= bus.sram_din[8*l +: 8];
      end else begin
         bus.sram_dout <= mem[bus.sram_addr];
      end
   end

   int n_vec = 0, n_err = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: shadow memory plus a queue of accepted reads (data, accept cycle)
   typedef struct { logic [31:0] data; int t; } rsp_t;
   rsp_t        q[$];
   logic [31:0] ref_mem [1024];
   int          cyc = 0, rsp_cnt = 0;
   logic        exp_v, exp_r, pop_e, fire_e;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rstb) begin
         q.delete();
         chk("rst_req_ready", 32'(bus.req_ready), 0);
         chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
         chk("rst_sram_we",   32'(bus.sram_we), 0);
         chk("rst_wmask",     32'(bus.sram_wmask), 0);
         chk("rst_busy",      32'(bus.busy), 0);
         chk("rst_rdata",     bus.rsp_rdata, 0);
      end else begin
         exp_v  = (q.size() > 0) && (cyc >= q[0].t + 2);
         pop_e  = exp_v & bus.rsp_ready;
         exp_r  = bus.req_we || ((q.size() - int'(pop_e)) < 2);
         fire_e = bus.req_valid & exp_r;
         chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
         if (exp_v) chk("rsp_rdata", bus.rsp_rdata, q[0].data);
         chk("req_ready",  32'(bus.req_ready), 32'(exp_r));
         chk("busy",       32'(bus.busy), 32'(q.size() != 0));
         chk("sram_we",    32'(bus.sram_we), 32'(fire_e & bus.req_we));
         chk("sram_wmask", 32'(bus.sram_wmask), (fire_e & bus.req_we) ? 32'(bus.req_wmask) : 0);
         chk("sram_addr",  32'(bus.sram_addr), 32'(bus.req_addr));
         chk("sram_din",   bus.sram_din, bus.req_wdata);
         if (pop_e) begin
            void'(q.pop_front());
            rsp_cnt++;
         end
         if (fire_e) begin
            if (bus.req_we) begin
               for (int l = 0; l < 4; l++)
                  if (bus.req_wmask[l]) ref_mem[bus.req_addr][8*l +: 8] = bus.req_wdata[8*l +: 8];
            end else begin
               q.push_back('{data: ref_mem[bus.req_addr], t: cyc});
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic we, input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
      bit ok = 0;
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d; bus.req_wmask = m;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.req_ready) begin ok = 1; break; end
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      if (!ok) chk("send_timeout", 0, 1);
   endtask

   task automatic rd_word(input logic [9:0] a, output logic [31:0] d);
      bit ok = 0;
      d = '0;
      send(1'b0, a, 32'h0, 4'h0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.rsp_valid && bus.rsp_ready) begin d = bus.rsp_rdata; ok = 1; break; end
      end
      @(posedge clk); #1;
      if (!ok) chk("rd_timeout", 0, 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 50; i++) begin
         if (!bus.busy) break;
         @(posedge clk); #1;
      end
      chk("drain_busy", 32'(bus.busy), 0);
   endtask

   logic [31:0] d;
   int k, acc, base, nrdy;

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = mem[i];
      end
      bus.req_valid = 0; bus.req_we = 0; bus.req_wmask = 0; bus.req_addr = 0;
      bus.req_wdata = 0; bus.rsp_ready = 1;
      idle(3);
      rstb = 1'b1;
      idle(1);

      // basic write/read, latency checked by the model
      send(1'b1, 10'h005, 32'hDEADBEEF, 4'hF);
      rd_word(10'h005, d);
      chk("basic_rd", d, 32'hDEADBEEF);
      idle(1);
      chk("basic_busy", 32'(bus.busy), 0);

      // byte masking
      send(1'b1, 10'h3FF, 32'h11223344, 4'hF);
      send(1'b1, 10'h3FF, 32'hAABBCCDD, 4'h5);
      rd_word(10'h3FF, d);
      chk("mask_rd", d, 32'h11BB33DD);
      send(1'b1, 10'h3FF, 32'hFFFFFFFF, 4'h0);
      rd_word(10'h3FF, d);
      chk("mask0_rd", d, 32'h11BB33DD);

      // backpressure: only two reads fit while the consumer stalls
      base = rsp_cnt; bus.rsp_ready = 0; k = 1; acc = 0;
      for (int c = 0; c < 4; c++) begin
         bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 10'(k);
         @(negedge clk);
         if (bus.req_ready) begin k++; acc++; end
         @(posedge clk); #1;
      end
      chk("bp_accepted", 32'(acc), 2);
      bus.req_valid = 0;
      idle(3);
      chk("bp_hold_vld", 32'(bus.rsp_valid), 1);
      chk("bp_hold_data", bus.rsp_rdata, ref_mem[1]);
      bus.rsp_ready = 1;
      for (int c = 0; c < 20 && k <= 4; c++) begin
         bus.req_valid = 1; bus.req_addr = 10'(k);
         @(negedge clk);
         if (bus.req_ready) k++;
         @(posedge clk); #1;
      end
      bus.req_valid = 0;
      drain();
      chk("bp_count", 32'(rsp_cnt - base), 4);

      // streaming: one read per cycle
      base = rsp_cnt; nrdy = 0;
      for (int i = 0; i < 16; i++) begin
         bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 10'(16 + i);
         @(negedge clk);
         if (bus.req_ready) nrdy++;
         @(posedge clk); #1;
      end
      bus.req_valid = 0;
      chk("stream_ready", 32'(nrdy), 16);
      drain();
      chk("stream_count", 32'(rsp_cnt - base), 16);

      // write then read next cycle
      send(1'b1, 10'h00A, 32'h5A5A5A5A, 4'hF);
      rd_word(10'h00A, d);
      chk("hazard_rd", d, 32'h5A5A5A5A);

      // reset with one read buffered and one in flight
      bus.rsp_ready = 0;
      send(1'b0, 10'h001, 32'h0, 4'h0);
      send(1'b0, 10'h002, 32'h0, 4'h0);
      rstb = 1'b0;
      bus.req_valid = 1; bus.req_we = 1; bus.req_wmask = 4'hF; bus.req_addr = 10'h003;
      #1;
      chk("mid_rst_vld", 32'(bus.rsp_valid), 0);
      chk("mid_rst_we",  32'(bus.sram_we), 0);
      idle(2);
      bus.req_valid = 0; bus.rsp_ready = 1;
      rstb = 1'b1;
      base = rsp_cnt;
      idle(5);
      chk("post_rst_none", 32'(rsp_cnt - base), 0);
      rd_word(10'h007, d);
      chk("post_rst_rd", d, ref_mem[7]);

      // random traffic against the model
      for (int c = 0; c < 400; c++) begin
         bus.req_valid = 1'($urandom % 2);
         bus.req_we    = ($urandom % 3) == 0;
         bus.req_addr  = 10'($urandom % 16);
         bus.req_wdata = $urandom;
         bus.req_wmask = 4'($urandom);
         bus.rsp_ready = ($urandom % 4) != 0;
         idle(1);
      end
      bus.req_valid = 0; bus.rsp_ready = 1;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
